// File: rtl/stopwatch_disp_mux.sv
// -----------------------------------------------------------------------------
// stopwatch_disp_mux
//
// Time-multiplexed four-digit seven-segment driver for the Basys 3
// common-anode display. It shows the stopwatch digits in M.SS.D format.
// One digit is lit per refresh slot of REFRESH_DIV clock cycles. The four
// input digits are captured once per full scan frame, on the idx 3->0 wrap,
// so a single frame never mixes old and new digits.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit stays lit (>= 2)
//   DP_MASK     : bit i = 1 lights the decimal point on digit i
//
// Ports
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   d3, d2, d1, d0 : BCD digits (d3 = minutes, d0 = tenths of a second)
//   blank          : 1 = all anodes off; scanning continues underneath
//   an             : anode enables, active-low, an[3] is the leftmost digit
//   seg            : segments {g,f,e,d,c,b,a}, active-low
//   dp             : decimal point, active-low
//
// Build option
//   DISP_LZB_EN : when defined, a zero on the minutes digit (digit 3) is
//                 blanked. Its anode and decimal point stay driven, so the
//                 display reads " .SS.D".
// -----------------------------------------------------------------------------
module stopwatch_disp_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter logic [3:0]  DP_MASK     = 4'b1010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned    CNT_W    = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 32'd1);

  localparam logic [6:0] SEG_RESET = 7'b1000000;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash (g only)
  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  // One-hot-low anode pattern for a digit index
  function automatic logic [3:0] an_decode(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = 4'b1110;
      2'd1:    pat = 4'b1101;
      2'd2:    pat = 4'b1011;
      2'd3:    pat = 4'b0111;
      default: pat = 4'b1111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [3:0]       s3_r;
  logic [3:0]       s2_r;
  logic [3:0]       s1_r;
  logic [3:0]       s0_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  logic             tick_s;
  logic             wrap_s;
  logic [1:0]       idx_next_s;
  logic [3:0]       digit_val_s;
  logic [6:0]       seg_next_s;
  logic [3:0]       an_next_s;
  logic             dp_next_s;

  // Slot boundary, frame boundary and the index the outputs will show next
  always_comb begin
    tick_s     = (cnt_r == CNT_LAST);
    wrap_s     = tick_s && (idx_r == 2'd3);
    idx_next_s = idx_r;
    if (tick_s) begin
      idx_next_s = idx_r + 2'd1;
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Value of the next digit. On the wrap edge the snapshot is being loaded
  // in the same cycle, so digit 0 comes straight from the input instead of
  // the stale snapshot register.
  always_comb begin
    digit_val_s = s0_r;
    if (wrap_s) begin
      digit_val_s = d0;
    end else begin
      case (idx_next_s)
        2'd0:    digit_val_s = s0_r;
        2'd1:    digit_val_s = s1_r;
        2'd2:    digit_val_s = s2_r;
        2'd3:    digit_val_s = s3_r;
        default: digit_val_s = s0_r;
      endcase
    end
  end

  // Next segment, anode and decimal-point patterns
  always_comb begin
    seg_next_s = seg_decode(digit_val_s);
`ifdef DISP_LZB_EN
    if ((idx_next_s == 2'd3) && (digit_val_s == 4'd0)) begin
      seg_next_s = SEG_OFF;
    end else begin
      seg_next_s = seg_decode(digit_val_s);
    end
`endif
    if (blank) begin
      an_next_s = 4'b1111;
    end else begin
      an_next_s = an_decode(idx_next_s);
    end
    dp_next_s = ~DP_MASK[idx_next_s];
  end

  // Refresh divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else begin
      if (tick_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
      idx_r <= idx_next_s;
    end
  end

  // Per-frame snapshot of the input digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_r <= 4'd0;
      s2_r <= 4'd0;
      s1_r <= 4'd0;
      s0_r <= 4'd0;
    end else if (wrap_s) begin
      s3_r <= d3;
      s2_r <= d2;
      s1_r <= d1;
      s0_r <= d0;
    end else begin
      s3_r <= s3_r;
      s2_r <= s2_r;
      s1_r <= s1_r;
      s0_r <= s0_r;
    end
  end

  // Registered display outputs; they only move on a slot edge or one edge
  // after blank changes, because their next values are stable otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= 4'b1110;
      seg_r <= SEG_RESET;
      dp_r  <= ~DP_MASK[0];
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_stopwatch_disp_mux.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_disp_mux
//
// Scoreboard bench for stopwatch_disp_mux with REFRESH_DIV = 4. The stimulus
// process drives directed vectors and queues hand-computed {an, seg, dp}
// values tagged with the time at which they must be visible. A separate
// monitor process pops each entry, waits for its time and compares.
// Slot k means the negedge just after the k-th rising edge since the latest
// reset release; tick edges are multiples of 4 and frame wraps multiples of 16.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_disp_mux;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
`ifdef DISP_LZB_EN
  localparam logic [6:0] SEG_D3_ZERO = 7'b1111111;
`else
  localparam logic [6:0] SEG_D3_ZERO = 7'b1000000;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] d3, d2, d1, d0;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  stopwatch_disp_mux #(
    .REFRESH_DIV(4),
    .DP_MASK    (4'b1010)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d3   (d3),
    .d2   (d2),
    .d1   (d1),
    .d0   (d0),
    .blank(blank),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] t;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [63:0] t0;
  int    k_now;

  task automatic push_t(input logic [63:0] t, input logic [3:0] a,
                        input logic [6:0] s, input logic d, input string nm);
    exp_t e;
    e.t   = t;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic push_k(input int k, input logic [3:0] a,
                        input logic [6:0] s, input logic d, input string nm);
    push_t(t0 + 64'(k) * 64'd10, a, s, d, nm);
  endtask

  task automatic adv_to(input int k);
    while (k_now < k) begin
      @(negedge clk);
      k_now = k_now + 1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t0    = $time;
    k_now = 0;
  endtask

  // Monitor: pop, wait for the tagged time, compare
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      while (sb_q.size() == 0) #1;
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      if (e.t > $time) #(e.t - $time);
      n_checks = n_checks + 1;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s @%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 nm, $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    blank = 1'b0;
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    t0 = 64'd0;
    k_now = 0;

    push_t(64'd12, 4'b1110, SEG_0, 1'b1, "reset_state");
    #13;
    release_reset();

    // Scan order from reset, all digits zero
    push_k(1,  4'b1110, SEG_0,       1'b1, "scan_d0");
    push_k(3,  4'b1110, SEG_0,       1'b1, "scan_d0_hold");
    push_k(4,  4'b1101, SEG_0,       1'b0, "scan_d1");
    push_k(8,  4'b1011, SEG_0,       1'b1, "scan_d2");
    push_k(11, 4'b1011, SEG_0,       1'b1, "scan_d2_hold");
    push_k(12, 4'b0111, SEG_D3_ZERO, 1'b0, "scan_d3");
    push_k(16, 4'b1110, SEG_0,       1'b1, "scan_wrap");
    // Frame in progress when inputs change keeps old digits
    push_k(24, 4'b1011, SEG_0,       1'b1, "frame_old_d2");
    push_k(28, 4'b0111, SEG_D3_ZERO, 1'b0, "frame_old_d3");
    // Next frame shows 1.23.4
    push_k(32, 4'b1110, SEG_4,       1'b1, "frame_new_d0");
    push_k(36, 4'b1101, SEG_3,       1'b0, "frame_new_d1");
    push_k(40, 4'b1011, SEG_2,       1'b1, "frame_new_d2");
    push_k(44, 4'b0111, SEG_1,       1'b0, "frame_new_d3");
    // Invalid BCD on d1
    push_k(48, 4'b1110, SEG_4,       1'b1, "bcd_d0");
    push_k(52, 4'b1101, SEG_DASH,    1'b0, "bcd_invalid_d1");
    push_k(56, 4'b1011, SEG_2,       1'b1, "bcd_d2");
    // Blank for 10 cycles from slot 58
    push_k(58, 4'b1011, SEG_2,       1'b1, "blank_before_edge");
    push_k(59, 4'b1111, SEG_2,       1'b1, "blank_on");
    push_k(60, 4'b1111, SEG_1,       1'b0, "blank_seg_d3");
    push_k(64, 4'b1111, SEG_4,       1'b1, "blank_seg_d0");
    push_k(68, 4'b1111, SEG_DASH,    1'b0, "blank_last");
    push_k(69, 4'b1101, SEG_DASH,    1'b0, "blank_release");
    push_k(72, 4'b1011, SEG_2,       1'b1, "blank_phase_kept");

    adv_to(20);
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    adv_to(44);
    d1 = 4'hC;
    adv_to(58);
    blank = 1'b1;
    adv_to(68);
    blank = 1'b0;

    // Asynchronous reset while idx = 2, away from any clock edge
    adv_to(74);
    push_k(74, 4'b1011, SEG_2, 1'b1, "pre_reset_d2");
    push_t(t0 + 64'd743, 4'b1110, SEG_0, 1'b1, "async_reset");
    push_t(t0 + 64'd748, 4'b1110, SEG_0, 1'b1, "async_reset_hold");
    #2;
    rst_n = 1'b0;
    release_reset();

    push_k(1,  4'b1110, SEG_0, 1'b1, "restart_d0");
    push_k(4,  4'b1101, SEG_0, 1'b0, "restart_d1");
    push_k(16, 4'b1110, SEG_4, 1'b1, "restart_wrap");
    // Minutes digit zero, then seven
    push_k(44, 4'b0111, SEG_D3_ZERO, 1'b0, "lzb_d3_zero");
    push_k(48, 4'b1110, SEG_4,       1'b1, "lzb_d0");
    push_k(52, 4'b1101, SEG_DASH,    1'b0, "lzb_d1");
    push_k(60, 4'b0111, SEG_7,       1'b0, "lzb_d3_seven");

    adv_to(16);
    d3 = 4'd0;
    adv_to(44);
    d3 = 4'd7;
    adv_to(64);

    n_checks = n_checks + 1;
    if (sb_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
